rf_wb_arbiter: RTL and testbench
================================

// Module: rf_wb_arbiter
// PURPOSE
//  Shares the single register-file write port among N writeback sources (ALU, load unit, CSR, ...).
//  Each source has a small FIFO; a round-robin arbiter drains one entry per cycle into the RF port.
//  Writes to x0 are discarded at enqueue.
//  Exports a per-register pending mask so decode can stall RAW/WAW hazards on queued writes.
// PARAMETERS
//  NUM_SRC    2  number of writeback requesters (>=2)
//  FIFO_DEPTH 2  entries per source FIFO (power of 2, >=2)
// PORTS
//  clk           in   1                   clock
//  rst           in   1                   synchronous, active-high reset
//  req_valid     in   NUM_SRC             source i presents a write
//  req_ready     out  NUM_SRC             source i FIFO can accept
//  req_addr      in   NUM_SRC x reg_ind_t destination register per source, packed [NUM_SRC-1:0]
//  req_data      in   NUM_SRC x data_t    write data per source, packed [NUM_SRC-1:0]
//  rf_we         out  1                   RF write enable
//  rf_waddr      out  reg_ind_t           RF write address
//  rf_wdata      out  data_t              RF write data
//  pending_mask  out  32                  bit r=1: a write to xr is queued and not yet issued
//  busy          out  1                   any FIFO non-empty
// BEHAVIOUR
//  - Reset: FIFOs emptied, RR pointer=0 (source 0 favoured first).
//    During any rst cycle: rf_we=0, req_ready=0, pending_mask=0, busy=0. Reset mid-drain drops all queued entries.
//  - Accept: enqueue on req_valid[i]&&req_ready[i] at posedge.
//    req_ready[i] = !full[i]; it is registered-state only, with no same-cycle pop pass-through.
//  - x0: a handshake with req_addr==0 completes normally, but nothing is stored and pending_mask is unaffected.
//  - Latency: an entry accepted at edge t drives rf_we during cycle t+1 at the earliest, and is written into the RF at edge t+1.
//    There is no combinational input-to-RF path.
//  - Arbitration: each cycle, if any FIFO is non-empty, grant exactly one non-empty source.
//    Search starts at (last_grant+1) mod NUM_SRC. The granted head drives rf_waddr/rf_wdata with rf_we=1, and is popped at the edge.
//    last_grant updates only on a grant.
//    If all FIFOs are empty: rf_we=0, rf_waddr=0, rf_wdata=0, and last_grant holds.
//  - Throughput: one RF write per cycle while any FIFO is non-empty.
//    A lone active source drains back-to-back and is never starved.
//  - Simultaneous push+pop on the same FIFO: legal when not full. Count is unchanged; pointers wrap mod FIFO_DEPTH.
//  - Full: req_ready[i]=0. A held req_valid is accepted the cycle after a pop frees a slot.
//  - pending_mask: the combinational OR over all valid entries of all FIFOs, as a one-hot of rd.
//    This includes the entry being issued this cycle, whose bit clears after the edge if no other entry targets it.
//    Bit 0 is always 0.
//  - Ordering: FIFO order is preserved per source. There is no ordering guarantee across sources.
//    Upstream must not enqueue rd from source j while pending_mask[rd]=1 from source i≠j.
//    Violating this is a protocol error and is flagged by a bench assertion. The design does not handle it.
// STRUCTURE
//  - CorePack additions:
//    typedef struct packed {reg_ind_t rd; data_t data;} wb_req_t;
//    localparam WB_NUM_SRC=2.
//  - Sub-module wb_fifo: synchronous FIFO of wb_req_t, parameter DEPTH.
//    Ports: push, pop, din, dout, full, empty, plus an entry-valid/rd vector exposed for pending_mask.
//    One instance per source via generate.
//  - Top level: the RR grant logic (priority rotate), the output mux, and the pending_mask reduction.
// TESTING
//  1. Reset, then src0 writes x5=0x1111 at cycle 1.
//     -> rf_we=1, waddr=5, wdata=0x1111 in cycle 2; pending_mask[5]=1 during cycle 2 only.
//  2. src0 (x1=A) and src1 (x2=B) both valid in the same cycle after reset.
//     -> cycle+1 writes x1, cycle+2 writes x2. Then both sources stream continuously.
//     -> grants alternate 0,1,0,1 with rf_we held at 1.
//  3. src1 pushes 3 writes back-to-back with FIFO_DEPTH=2 while src0 floods.
//     -> req_ready[1] drops when full. Every write appears on the RF port exactly once, in per-source order, with none lost.
//  4. src0 writes x0=0xDEAD.
//     -> req_ready=1, handshake completes, rf_we stays 0, pending_mask=0, busy=0.
//  5. Fill both FIFOs, then assert rst for 1 cycle mid-drain.
//     -> rf_we=0 that cycle. After reset: busy=0, pending_mask=0, and no stale write ever issues.
//     -> The next single src1 write issues first with last_grant=0.
//  6. Random valid/addr/data over 10k cycles against a scoreboard model.
//     -> Every accepted non-x0 write reaches the RF within the bound.
//     -> Check: FIFO_DEPTH*NUM_SRC cycles of acceptance, with no duplicates.

Source files
------------

// File: rtl/rf_wb_arbiter_pkg.sv
// Writeback arbiter types shared by the RF write-port slice.
// Register index/data types, the queued write entry, and default sizes.
package rf_wb_arbiter_pkg;

  localparam int XLEN     = 32;
  localparam int NUM_REGS = 32;

  typedef logic [4:0]      reg_ind_t;
  typedef logic [XLEN-1:0] data_t;

  typedef struct packed {
    reg_ind_t rd;
    data_t    data;
  } wb_req_t;

  localparam int WB_NUM_SRC    = 2;
  localparam int WB_FIFO_DEPTH = 2;

  // x0 never reports as pending
  function automatic logic [NUM_REGS-1:0] rd_onehot(reg_ind_t rd);
    logic [NUM_REGS-1:0] oh;
    oh     = '0;
    oh[rd] = 1'b1;
    oh[0]  = 1'b0;
    return oh;
  endfunction

endpackage

// File: rtl/rf_wb_arbiter_if.sv
// Writeback request bus and RF write port bundle.
// master: writeback sources + RF/decode side; slave: the arbiter.
interface rf_wb_arbiter_if
  import rf_wb_arbiter_pkg::*;
#(
  parameter int NUM_SRC = WB_NUM_SRC
);

  logic     [NUM_SRC-1:0] req_valid;
  logic     [NUM_SRC-1:0] req_ready;
  reg_ind_t [NUM_SRC-1:0] req_addr;
  data_t    [NUM_SRC-1:0] req_data;

  logic                   rf_we;
  reg_ind_t               rf_waddr;
  data_t                  rf_wdata;
  logic     [31:0]        pending_mask;
  logic                   busy;

  modport master (
    output req_valid,
    output req_addr,
    output req_data,
    input  req_ready,
    input  rf_we,
    input  rf_waddr,
    input  rf_wdata,
    input  pending_mask,
    input  busy
  );

  modport slave (
    input  req_valid,
    input  req_addr,
    input  req_data,
    output req_ready,
    output rf_we,
    output rf_waddr,
    output rf_wdata,
    output pending_mask,
    output busy
  );

endinterface

// File: rtl/rf_wb_arbiter_fifo.sv
// Per-source writeback FIFO (module wb_fifo), ring buffer of wb_req_t.
// Ports: clk, rst, push_i, pop_i, din_i, dout_o, full_o, empty_o,
// ent_vld_o/ent_rd_o expose every slot for the pending-register mask.
module wb_fifo
  import rf_wb_arbiter_pkg::*;
#(
  parameter int DEPTH = WB_FIFO_DEPTH
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 push_i,
  input  logic                 pop_i,
  input  wb_req_t              din_i,
  output wb_req_t              dout_o,
  output logic                 full_o,
  output logic                 empty_o,
  output logic     [DEPTH-1:0] ent_vld_o,
  output reg_ind_t [DEPTH-1:0] ent_rd_o
);

  localparam int AW = $clog2(DEPTH);

  wb_req_t          mem_q [DEPTH];
  logic [AW-1:0]    wp_q;
  logic [AW-1:0]    rp_q;
  logic [DEPTH-1:0] vld_q;
  logic [DEPTH-1:0] vld_d;
  logic             do_push;
  logic             do_pop;

  // per-slot valid bits: full/empty fall out of the pointed-to slot
  assign full_o  = vld_q[wp_q];
  assign empty_o = ~vld_q[rp_q];
  assign do_push = push_i & ~full_o;
  assign do_pop  = pop_i & ~empty_o;
  assign dout_o  = mem_q[rp_q];
  assign ent_vld_o = vld_q;

  always_comb begin
    for (int e = 0; e < DEPTH; e++) begin
      ent_rd_o[e] = mem_q[e].rd;
    end
  end

  always_comb begin
    vld_d = vld_q;
    if (do_pop) vld_d[rp_q] = 1'b0;
    if (do_push) vld_d[wp_q] = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wp_q  <= '0;
      rp_q  <= '0;
      vld_q <= '0;
    end else begin
      vld_q <= vld_d;
      if (do_push) wp_q <= wp_q + AW'(1);
      if (do_pop) rp_q <= rp_q + AW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem_q[wp_q] <= din_i;
  end

endmodule

// File: rtl/rf_wb_arbiter.sv
// Shares the RF write port among NUM_SRC writeback sources via round-robin.
// Ports: clk, rst (sync, active-high), bus (slave): per-source req
// valid/ready/addr/data, RF we/waddr/wdata, pending_mask, busy.
module rf_wb_arbiter
  import rf_wb_arbiter_pkg::*;
#(
  parameter int NUM_SRC    = WB_NUM_SRC,
  parameter int FIFO_DEPTH = WB_FIFO_DEPTH
) (
  input logic            clk,
  input logic            rst,
  rf_wb_arbiter_if.slave bus
);

  localparam int PW = $clog2(NUM_SRC);

  logic     [NUM_SRC-1:0]    rdy;
  logic     [NUM_SRC-1:0]    push;
  logic     [NUM_SRC-1:0]    pop;
  logic     [NUM_SRC-1:0]    full;
  logic     [NUM_SRC-1:0]    empty;
  wb_req_t                   din  [NUM_SRC];
  wb_req_t                   head [NUM_SRC];
  logic     [FIFO_DEPTH-1:0] ent_vld [NUM_SRC];
  reg_ind_t [FIFO_DEPTH-1:0] ent_rd  [NUM_SRC];

  logic [PW-1:0] ptr_q;
  logic [PW-1:0] ptr_d;
  logic [PW-1:0] gnt_idx;
  logic [PW-1:0] cand;
  logic          gnt_vld;

  logic          we;
  reg_ind_t      waddr;
  data_t         wdata;
  logic [31:0]   pmask;

  // ready is pure state: a pop this cycle does not open a slot until next
  assign rdy = rst ? '0 : ~full;

  for (genvar g = 0; g < NUM_SRC; g++) begin : g_src
    // x0 handshakes complete but are never stored
    assign push[g] = bus.req_valid[g] & rdy[g] &
                     (bus.req_addr[g] != '0);
    assign pop[g]  = gnt_vld & ~rst & (gnt_idx == PW'(g));
    assign din[g]  = '{rd: bus.req_addr[g], data: bus.req_data[g]};

    wb_fifo #(
      .DEPTH(FIFO_DEPTH)
    ) u_fifo (
      .clk       (clk),
      .rst       (rst),
      .push_i    (push[g]),
      .pop_i     (pop[g]),
      .din_i     (din[g]),
      .dout_o    (head[g]),
      .full_o    (full[g]),
      .empty_o   (empty[g]),
      .ent_vld_o (ent_vld[g]),
      .ent_rd_o  (ent_rd[g])
    );
  end

  // ptr_q is the first source searched; it sits one past the last grant
  always_comb begin
    gnt_vld = 1'b0;
    gnt_idx = '0;
    cand    = '0;
    for (int k = 0; k < NUM_SRC; k++) begin
      cand = PW'((int'(ptr_q) + k) % NUM_SRC);
      if (!gnt_vld && !empty[cand]) begin
        gnt_vld = 1'b1;
        gnt_idx = cand;
      end
    end
  end

  assign ptr_d = (gnt_idx == PW'(NUM_SRC - 1)) ? '0 : gnt_idx + 1'b1;

  always_ff @(posedge clk) begin
    if (rst) begin
      ptr_q <= '0;
    end else if (gnt_vld) begin
      ptr_q <= ptr_d;
    end
  end

  always_comb begin
    we    = 1'b0;
    waddr = '0;
    wdata = '0;
    if (gnt_vld && !rst) begin
      we    = 1'b1;
      waddr = head[gnt_idx].rd;
      wdata = head[gnt_idx].data;
    end
  end

  // includes the head being issued now; its bit drops after the pop
  always_comb begin
    pmask = '0;
    for (int i = 0; i < NUM_SRC; i++) begin
      for (int e = 0; e < FIFO_DEPTH; e++) begin
        if (ent_vld[i][e]) pmask = pmask | rd_onehot(ent_rd[i][e]);
      end
    end
    if (rst) pmask = '0;
  end

  assign bus.req_ready    = rdy;
  assign bus.rf_we        = we;
  assign bus.rf_waddr     = waddr;
  assign bus.rf_wdata     = wdata;
  assign bus.pending_mask = pmask;
  assign bus.busy         = ~rst & ~(&empty);

endmodule

// File: tb/tb_rf_wb_arbiter.sv
// Bench for rf_wb_arbiter: directed vectors plus a queue-model scoreboard.
// Two sources, depth-2 FIFOs.
module tb_rf_wb_arbiter;
  import rf_wb_arbiter_pkg::*;

  localparam int NS  = 2;
  localparam int FD  = 2;
  localparam int LAT = NS * FD;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  rf_wb_arbiter_if #(.NUM_SRC(NS)) bus ();

  rf_wb_arbiter #(
    .NUM_SRC   (NS),
    .FIFO_DEPTH(FD)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  typedef struct {
    reg_ind_t rd;
    data_t    data;
    int       t;
  } ent_t;

  ent_t q0[$];
  ent_t q1[$];
  int   checks = 0;
  int   errors = 0;
  int   cyc = 0;
  int   ptr = 0;
  int   wcnt [NS];

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(string tag, logic [31:0] got, logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  function automatic logic has_rd(int s, reg_ind_t rd);
    logic hit;
    hit = 1'b0;
    if (s == 0) begin
      foreach (q0[k]) if (q0[k].rd == rd) hit = 1'b1;
    end else begin
      foreach (q1[k]) if (q1[k].rd == rd) hit = 1'b1;
    end
    return hit;
  endfunction

  // scoreboard: model state matches DUT state between edges
  logic [31:0]   em;
  logic [NS-1:0] er;
  int            gs;
  ent_t          he;
  ent_t          ne;

  always @(negedge clk) begin
    if (rst) begin
      chk("rst_we", 32'(bus.rf_we), 0);
      chk("rst_ready", 32'(bus.req_ready), 0);
      chk("rst_busy", 32'(bus.busy), 0);
      chk("rst_pmask", bus.pending_mask, 0);
      q0.delete();
      q1.delete();
      ptr = 0;
    end else begin
      em = '0;
      foreach (q0[k]) em[q0[k].rd] = 1'b1;
      foreach (q1[k]) em[q1[k].rd] = 1'b1;
      chk("pmask", bus.pending_mask, em);
      er[0] = q0.size() < FD;
      er[1] = q1.size() < FD;
      chk("ready", 32'(bus.req_ready), 32'(er));
      chk("busy", 32'(bus.busy), 32'(q0.size() + q1.size() != 0));
      gs = -1;
      if (q0.size() != 0 && q1.size() != 0) gs = ptr;
      else if (q0.size() != 0) gs = 0;
      else if (q1.size() != 0) gs = 1;
      if (gs >= 0) begin
        he = (gs == 0) ? q0.pop_front() : q1.pop_front();
        chk("we", 32'(bus.rf_we), 1);
        chk("waddr", 32'(bus.rf_waddr), 32'(he.rd));
        chk("wdata", bus.rf_wdata, he.data);
        chk("latency", 32'(cyc - he.t <= LAT), 1);
        ptr = (gs + 1) % NS;
        wcnt[gs]++;
      end else begin
        chk("idle_we", 32'(bus.rf_we), 0);
        chk("idle_waddr", 32'(bus.rf_waddr), 0);
        chk("idle_wdata", bus.rf_wdata, 0);
      end
      for (int j = 0; j < NS; j++) begin
        if (bus.req_valid[j] && er[j] && bus.req_addr[j] != '0) begin
          chk("proto_raw", 32'(has_rd(1 - j, bus.req_addr[j])), 0);
          ne = '{rd: bus.req_addr[j], data: bus.req_data[j], t: cyc};
          if (j == 0) q0.push_back(ne);
          else q1.push_back(ne);
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set(int s, logic v, reg_ind_t a, data_t d);
    bus.req_valid[s] = v;
    bus.req_addr[s]  = a;
    bus.req_data[s]  = d;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    tick();
    rst = 1'b0;
  endtask

  task automatic drain();
    for (int k = 0; k < 40 && bus.busy; k++) tick();
    chk("drain_busy", 32'(bus.busy), 0);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog cycles=%0d", cyc);
    $fatal(1);
  end

  logic     saw_full;
  int       n;
  int       c1;
  data_t    cv [3];
  reg_ind_t a0;
  reg_ind_t a1;
  logic     v0;
  logic     v1;

  initial begin
    bus.req_valid = '0;
    bus.req_addr  = '0;
    bus.req_data  = '0;
    wcnt[0] = 0;
    wcnt[1] = 0;
    cv[0] = 32'hC000_0000;
    cv[1] = 32'hC000_0001;
    cv[2] = 32'hC000_0002;
    tick();
    tick();
    @(negedge clk);
    chk("reset_we", 32'(bus.rf_we), 0);
    chk("reset_ready", 32'(bus.req_ready), 0);
    tick();
    rst = 1'b0;
    @(negedge clk);
    chk("post_rst_ready", 32'(bus.req_ready), 3);
    chk("post_rst_busy", 32'(bus.busy), 0);

    // single write, one-cycle latency
    tick();
    set(0, 1'b1, 5'd5, 32'h1111);
    @(negedge clk);
    chk("t1_ready", 32'(bus.req_ready[0]), 1);
    chk("t1_we_pre", 32'(bus.rf_we), 0);
    tick();
    bus.req_valid = '0;
    @(negedge clk);
    chk("t1_we", 32'(bus.rf_we), 1);
    chk("t1_waddr", 32'(bus.rf_waddr), 5);
    chk("t1_wdata", bus.rf_wdata, 32'h1111);
    chk("t1_pmask", bus.pending_mask, 32'h20);
    chk("t1_busy", 32'(bus.busy), 1);
    tick();
    @(negedge clk);
    chk("t1_we_post", 32'(bus.rf_we), 0);
    chk("t1_pmask_post", bus.pending_mask, 0);

    // simultaneous start after reset, then continuous streaming
    tick();
    do_reset();
    set(0, 1'b1, 5'd1, 32'hAAAA_0000);
    set(1, 1'b1, 5'd2, 32'hBBBB_0000);
    tick();
    for (int k = 0; k < 6; k++) begin
      @(negedge clk);
      chk("t2_we", 32'(bus.rf_we), 1);
      chk("t2_waddr", 32'(bus.rf_waddr), (k % 2 == 0) ? 1 : 2);
      if (k == 0) chk("t2_wdata_a", bus.rf_wdata, 32'hAAAA_0000);
      if (k == 1) chk("t2_wdata_b", bus.rf_wdata, 32'hBBBB_0000);
      tick();
      bus.req_data[0] = 32'hAAAA_0001 + 32'(k);
      bus.req_data[1] = 32'hBBBB_0001 + 32'(k);
    end
    bus.req_valid = '0;
    drain();

    // src1 three back-to-back writes while src0 floods
    c1 = wcnt[1];
    saw_full = 1'b0;
    n = 0;
    for (int k = 0; k < 8; k++) begin
      set(0, 1'b1, 5'd3, 32'hF00D_0000 + 32'(k));
      set(1, n < 3, 5'd4, cv[n < 3 ? n : 2]);
      @(negedge clk);
      if (!bus.req_ready[1]) saw_full = 1'b1;
      if (bus.req_valid[1] && bus.req_ready[1]) n++;
      tick();
    end
    bus.req_valid = '0;
    drain();
    chk("t3_full_seen", 32'(saw_full), 1);
    chk("t3_pushed", n, 3);
    chk("t3_src1_writes", wcnt[1] - c1, 3);

    // x0 write: handshake only
    set(0, 1'b1, 5'd0, 32'hDEAD);
    @(negedge clk);
    chk("t4_ready", 32'(bus.req_ready[0]), 1);
    tick();
    bus.req_valid = '0;
    @(negedge clk);
    chk("t4_we", 32'(bus.rf_we), 0);
    chk("t4_pmask", bus.pending_mask, 0);
    chk("t4_busy", 32'(bus.busy), 0);

    // reset mid-drain
    tick();
    set(0, 1'b1, 5'd6, 32'h6666_0000);
    set(1, 1'b1, 5'd7, 32'h7777_0000);
    tick();
    tick();
    bus.req_valid = '0;
    chk("t5_busy_pre", 32'(bus.busy), 1);
    rst = 1'b1;
    @(negedge clk);
    chk("t5_rst_we", 32'(bus.rf_we), 0);
    tick();
    rst = 1'b0;
    @(negedge clk);
    chk("t5_busy", 32'(bus.busy), 0);
    chk("t5_pmask", bus.pending_mask, 0);
    chk("t5_we", 32'(bus.rf_we), 0);
    tick();
    set(1, 1'b1, 5'd9, 32'h5A5A);
    tick();
    bus.req_valid = '0;
    @(negedge clk);
    chk("t5_src1_we", 32'(bus.rf_we), 1);
    chk("t5_src1_waddr", 32'(bus.rf_waddr), 9);
    chk("t5_src1_wdata", bus.rf_wdata, 32'h5A5A);
    tick();
    @(negedge clk);
    chk("t5_no_stale", 32'(bus.rf_we), 0);
    tick();
    set(0, 1'b1, 5'd10, 32'h1010);
    set(1, 1'b1, 5'd11, 32'h1111_1111);
    tick();
    bus.req_valid = '0;
    @(negedge clk);
    chk("t5_rr_next", 32'(bus.rf_waddr), 10);
    drain();

    // random traffic against the scoreboard
    for (int k = 0; k < 10000; k++) begin
      v0 = 1'($urandom % 2);
      v1 = 1'($urandom % 2);
      a0 = 5'($urandom % 32);
      a1 = 5'($urandom % 32);
      if (has_rd(1, a0)) a0 = '0;
      if (has_rd(0, a1)) a1 = '0;
      if (v0 && a1 == a0) a1 = '0;
      set(0, v0, a0, $urandom);
      set(1, v1, a1, $urandom);
      tick();
    end
    bus.req_valid = '0;
    drain();
    chk("t6_model_empty", q0.size() + q1.size(), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
